// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx and the forthcoming uart_tx.
// Contents: receiver/transmitter state encoding, oversampling constants,
// and a counter-width helper.
package uart_pkg;

    // State encoding for the serial framing FSMs.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_START = S_START,
        ST_DATA  = S_DATA,
        ST_STOP  = S_STOP
    } uart_state_t;

    // Oversampling: eight ticks per bit. The start bit is checked half a bit
    // in, and every later sample is one full bit period after the previous one.
    localparam int         OS_RATE = 8;
    localparam logic [2:0] OS_MID  = 3'(OS_RATE / 2 - 1);
    localparam logic [2:0] OS_LAST = 3'(OS_RATE - 1);

    // Width of a counter that indexes n items. The result is never less than 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous peripheral inputs. Both flops reset
// to 1, so an idle-high line does not produce a false edge when reset is
// released.
// Ports: i_clk clock, i_rst synchronous active-high reset,
//        d asynchronous input, q synchronized output.
module uart_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage resynchronisation into the i_clk domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_BITS data bits (LSB first), and 1 stop bit,
// sampled with an 8x oversampling tick. Each received word is placed in a
// single holding register that uses a valid/ack handshake.
// Ports: i_clk, i_rst (sync, active-high), i_ce_x8 oversample tick,
//        i_rx serial line, i_ack consumer acknowledge pulse,
//        o_data held word, o_valid unacknowledged word present,
//        o_frame_err one-cycle bad-stop pulse, o_overrun sticky overwrite flag,
//        o_busy FSM not idle.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ce_x8,
    input  logic                 i_rx,
    input  logic                 i_ack,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);
    import uart_pkg::*;

    localparam int             BCW      = cnt_width(DATA_BITS);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state_r,   state_nxt_s;
    logic [2:0]           os_cnt_r,  os_cnt_nxt_s;
    logic [BCW-1:0]       bit_cnt_r, bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r,   shift_nxt_s;
    logic                 load_s;
    logic                 frame_err_s;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 frame_err_r;
    logic                 overrun_r;
    logic                 busy_r;

    uart_sync2 u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d     (i_rx),
        .q     (rx_s)
    );

    // Framing FSM next state. Nothing advances except on oversample ticks.
    always_comb begin
        state_nxt_s   = state_r;
        os_cnt_nxt_s  = os_cnt_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        load_s        = 1'b0;
        frame_err_s   = 1'b0;
        if (i_ce_x8) begin
            case (state_r)
                ST_IDLE: begin
                    os_cnt_nxt_s  = 3'd0;
                    bit_cnt_nxt_s = {BCW{1'b0}};
                    if (!rx_s) begin
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (os_cnt_r == OS_MID) begin
                        os_cnt_nxt_s  = 3'd0;
                        bit_cnt_nxt_s = {BCW{1'b0}};
                        // The line went high again before mid start bit, so
                        // this was a glitch and not a real start bit.
                        if (rx_s) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_DATA;
                        end
                    end else begin
                        os_cnt_nxt_s = os_cnt_r + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (os_cnt_r == OS_LAST) begin
                        // Bits arrive LSB first, so each new bit enters at the
                        // top. After the last shift, bit 0 is in position 0.
                        shift_nxt_s  = {rx_s, shift_r[DATA_BITS-1:1]};
                        os_cnt_nxt_s = 3'd0;
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_nxt_s = {BCW{1'b0}};
                            state_nxt_s   = ST_STOP;
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + BCW'(1'b1);
                        end
                    end else begin
                        os_cnt_nxt_s = os_cnt_r + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (os_cnt_r == OS_LAST) begin
                        // Return to IDLE at mid stop bit. This leaves time to
                        // catch a start bit that follows immediately.
                        state_nxt_s  = ST_IDLE;
                        os_cnt_nxt_s = 3'd0;
                        if (rx_s) begin
                            load_s = 1'b1;
                        end else begin
                            frame_err_s = 1'b1;
                        end
                    end else begin
                        os_cnt_nxt_s = os_cnt_r + 3'd1;
                    end
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    os_cnt_nxt_s  = 3'd0;
                    bit_cnt_nxt_s = {BCW{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM/counter state, plus the registered holding register and status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            os_cnt_r    <= 3'd0;
            bit_cnt_r   <= {BCW{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            data_r      <= {DATA_BITS{1'b0}};
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            os_cnt_r    <= os_cnt_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            frame_err_r <= frame_err_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            if (load_s) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
                // If an ack arrives on the same cycle, the old word was
                // consumed, so the new word does not count as an overrun.
                if (i_ack) begin
                    overrun_r <= 1'b0;
                end else if (valid_r) begin
                    overrun_r <= 1'b1;
                end
            end else if (i_ack && valid_r) begin
                valid_r   <= 1'b0;
                overrun_r <= 1'b0;
            end
        end
    end

    assign o_data      = data_r;
    assign o_valid     = valid_r;
    assign o_frame_err = frame_err_r;
    assign o_overrun   = overrun_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Serial frames are driven on tick-aligned bit
// boundaries, 8 ticks per bit, with a tick every 4 clocks. A behavioural model
// of the holding register/handshake predicts o_data, o_valid and o_overrun.
// Monitors count the cycles that o_frame_err and o_busy are high.
module tb_uart_rx;
    localparam int DB = 8;

    logic          i_clk   = 1'b0;
    logic          i_rst   = 1'b1;
    logic          i_ce_x8 = 1'b0;
    logic          i_rx    = 1'b1;
    logic          i_ack   = 1'b0;
    logic [DB-1:0] o_data;
    logic          o_valid;
    logic          o_frame_err;
    logic          o_overrun;
    logic          o_busy;

    int total = 0;
    int bad   = 0;
    int ferr_cycles = 0;
    int busy_cycles = 0;
    logic [1:0] ce_div = 2'd0;

    // Reference model of the consumer-visible state.
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;

    uart_rx #(.DATA_BITS(DB)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ce_x8     (i_ce_x8),
        .i_rx        (i_rx),
        .i_ack       (i_ack),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Oversample tick: one cycle in every four.
    always @(posedge i_clk) begin
        #1;
        ce_div  = ce_div + 2'd1;
        i_ce_x8 = (ce_div == 2'd0);
    end

    // Pulse-width monitors, sampled away from the active edge.
    always @(negedge i_clk) begin
        if (o_frame_err === 1'b1) ferr_cycles++;
        if (o_busy === 1'b1) busy_cycles++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next clock edge on which the tick was seen.
    task automatic wait_tick();
        do @(posedge i_clk); while (i_ce_x8 !== 1'b1);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    // Drives one frame that starts right after a tick edge. If ack_load is set,
    // i_ack is pulsed on the cycle of the stop sample: the falling edge is seen
    // on tick 1 (two sync cycles), the start sample is on tick 5, and the stop
    // sample is on tick 5 + 8*9 = 77.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_load);
        for (int k = 0; k < 10; k++) begin
            if (k == 0) i_rx = 1'b0;
            else if (k == 9) i_rx = stop;
            else i_rx = d[k-1];
            if (k == 9 && ack_load) begin
                wait_ticks(4);
                repeat (3) @(posedge i_clk);
                #1;
                i_ack = 1'b1;
                @(posedge i_clk);
                #1;
                i_ack = 1'b0;
                wait_ticks(3);
            end else begin
                wait_ticks(8);
            end
        end
        i_rx = 1'b1;
    endtask

    // Model: a good stop bit delivers the word. If the previous word was still
    // unconsumed and no ack came with it, it is lost.
    task automatic model_frame(input logic [7:0] d, input logic stop, input logic ack_load);
        if (stop) begin
            m_ovr   = ack_load ? 1'b0 : (m_ovr | m_valid);
            m_data  = d;
            m_valid = 1'b1;
        end else if (ack_load) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] d, input logic stop,
                                   input logic ack_load);
        int f0;
        f0 = ferr_cycles;
        send_frame(d, stop, ack_load);
        model_frame(d, stop, ack_load);
        check({tag, ".data"}, o_data, m_data);
        check({tag, ".valid"}, o_valid, m_valid);
        check({tag, ".overrun"}, o_overrun, m_ovr);
        check({tag, ".ferr_cycles"}, ferr_cycles - f0, stop ? 0 : 1);
    endtask

    task automatic pulse_ack();
        i_ack = 1'b1;
        @(posedge i_clk);
        #1;
        i_ack = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        wait_tick();
    endtask

    initial begin
        int b0;
        logic [7:0] rd;
        logic rs, ra;

        // Reset state.
        repeat (3) @(posedge i_clk);
        #1;
        check("rst.data", o_data, 0);
        check("rst.valid", o_valid, 0);
        check("rst.ferr", o_frame_err, 0);
        check("rst.overrun", o_overrun, 0);
        check("rst.busy", o_busy, 0);
        i_rst = 1'b0;
        wait_ticks(10);

        // Basic 8N1 frame followed by an ack.
        frame_and_check("a5", 8'hA5, 1'b1, 1'b0);
        pulse_ack();
        check("a5.ack_valid", o_valid, 0);

        // Two-tick low glitch: false start. Busy is high for 4 ticks = 16 cycles.
        b0 = busy_cycles;
        i_rx = 1'b0;
        wait_ticks(2);
        i_rx = 1'b1;
        wait_ticks(10);
        check("glitch.busy_cycles", busy_cycles - b0, 16);
        check("glitch.busy_end", o_busy, 0);
        check("glitch.valid", o_valid, 0);

        // Bad stop bit, then a good frame.
        frame_and_check("3c_badstop", 8'h3C, 1'b0, 1'b0);
        wait_ticks(10);
        frame_and_check("81", 8'h81, 1'b1, 1'b0);
        pulse_ack();

        // Back-to-back frames with no ack: overrun.
        frame_and_check("11", 8'h11, 1'b1, 1'b0);
        frame_and_check("22_ovr", 8'h22, 1'b1, 1'b0);
        pulse_ack();
        check("ovr.ack_valid", o_valid, 0);
        check("ovr.ack_overrun", o_overrun, 0);

        // Ack on the load cycle of the second frame: no overrun.
        frame_and_check("11b", 8'h11, 1'b1, 1'b0);
        frame_and_check("22_ackload", 8'h22, 1'b1, 1'b1);
        pulse_ack();

        // Leave valid and overrun set, then reset in the middle of DATA of 0xFF.
        frame_and_check("33", 8'h33, 1'b1, 1'b0);
        frame_and_check("44", 8'h44, 1'b1, 1'b0);
        i_rx = 1'b0;
        wait_ticks(8);
        i_rx = 1'b1;
        wait_ticks(20);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check("midrst.data", o_data, 0);
        check("midrst.valid", o_valid, 0);
        check("midrst.ferr", o_frame_err, 0);
        check("midrst.overrun", o_overrun, 0);
        check("midrst.busy", o_busy, 0);
        i_rst   = 1'b0;
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        wait_tick();
        wait_ticks(60);
        frame_and_check("5a", 8'h5A, 1'b1, 1'b0);
        pulse_ack();

        // Random frames: random data, occasional bad stop bit, random ack timing.
        for (int n = 0; n < 12; n++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 2) == 0);
            frame_and_check("rand", rd, rs, ra);
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                check("rand.ack_valid", o_valid, 0);
            end
            wait_ticks(rs ? $urandom_range(0, 3) : 10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
